// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port register file.
// Holds default widths, the clear-sweep state encoding and the flattened-port slice helper.
package regfile_pkg;

    localparam int unsigned DataWDef = 32;
    localparam int unsigned AddrWDef = 5;

    typedef enum logic {
        StIdle  = 1'b0,
        StSweep = 1'b1
    } state_e;

    // Lowest bit of element idx in a flattened bus of w-bit elements.
    function automatic int unsigned slice_lo(input int unsigned idx, input int unsigned w);
        return idx * w;
    endfunction

endpackage

// File: rtl/regfile_rdport.sv
// One combinational read port: zero-register override, write bypass and pending flag.
module regfile_rdport #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter bit          ZERO_REG = 1'b1,
    parameter bit          BYPASS   = 1'b1
) (
    input  logic [ADDR_W-1:0] raddr_i,
    input  logic [DATA_W-1:0] mem_word_i,
    input  logic              pend_bit_i,
    input  logic              wr_ok_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    output logic [DATA_W-1:0] rdata_o,
    output logic              rpend_o
);

    logic is_zero;
    logic byp_hit;

    // wr_ok_i already excludes dropped writes and writes during a sweep.
    assign is_zero = ZERO_REG && (raddr_i == '0);
    assign byp_hit = BYPASS && wr_ok_i && (wr_addr_i == raddr_i);

    always_comb begin
        rdata_o = mem_word_i;
        rpend_o = pend_bit_i;
        if (is_zero) begin
            rdata_o = '0;
            rpend_o = 1'b0;
        end else if (byp_hit) begin
            rdata_o = wr_data_i;
            rpend_o = 1'b0;
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-read-port register file with write bypass, pending scoreboard
// and a sequenced clear sweep that zeroes one register per cycle.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W   = DataWDef,
    parameter int unsigned ADDR_W   = AddrWDef,
    parameter int unsigned NUM_RD   = 2,
    parameter bit          ZERO_REG = 1'b1,
    parameter bit          BYPASS   = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we,
    input  logic [ADDR_W-1:0]        rd,
    input  logic [DATA_W-1:0]        dataIn,
    input  logic [NUM_RD*ADDR_W-1:0] raddr,
    output logic [NUM_RD*DATA_W-1:0] rdata,
    output logic [NUM_RD-1:0]        rpend,
    input  logic                     mark_en,
    input  logic [ADDR_W-1:0]        mark_addr,
    input  logic                     clr_req,
    output logic                     clr_busy,
    output logic                     clr_done
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DEPTH-1:0]  pend_q, pend_d;

    logic idle;
    logic wr_ok;
    logic mark_ok;

    assign idle    = (state_q == StIdle);
    assign wr_ok   = we && idle && !(ZERO_REG && (rd == '0));
    assign mark_ok = mark_en && idle && !(ZERO_REG && (mark_addr == '0));
    assign clr_busy = (state_q == StSweep);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        clr_done = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (clr_req) begin
                    state_d = StSweep;
                    cnt_d   = '0;
                end
            end
            StSweep: begin
                // cnt wraps to 0 exactly as the sweep exits.
                cnt_d = cnt_q + 1'b1;
                if (&cnt_q) begin
                    clr_done = 1'b1;
                    state_d  = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Mark is applied after the write clear so a same-address mark wins.
    always_comb begin
        pend_d = pend_q;
        if (clr_busy) begin
            pend_d[cnt_q] = 1'b0;
        end else begin
            if (wr_ok) pend_d[rd] = 1'b0;
            if (mark_ok) pend_d[mark_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (clr_busy) begin
            mem_q[cnt_q] <= '0;
        end else if (wr_ok) begin
            mem_q[rd] <= dataIn;
        end
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        localparam int unsigned LoA = slice_lo(i, ADDR_W);
        localparam int unsigned LoD = slice_lo(i, DATA_W);

        logic [ADDR_W-1:0] ra;
        assign ra = raddr[LoA +: ADDR_W];

        regfile_rdport #(
            .DATA_W  (DATA_W),
            .ADDR_W  (ADDR_W),
            .ZERO_REG(ZERO_REG),
            .BYPASS  (BYPASS)
        ) u_rdport (
            .raddr_i   (ra),
            .mem_word_i(mem_q[ra]),
            .pend_bit_i(pend_q[ra]),
            .wr_ok_i   (wr_ok),
            .wr_addr_i (rd),
            .wr_data_i (dataIn),
            .rdata_o   (rdata[LoD +: DATA_W]),
            .rpend_o   (rpend[i])
        );
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: a default instance (ZERO_REG=1, BYPASS=1) and an
// alternate instance (ZERO_REG=0, BYPASS=0) share stimulus and are checked against array models.
module tb_regfile_mp;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int NR    = 3;
    localparam int DEPTH = 32;

    logic              clk;
    logic              rst;
    logic              we;
    logic [AW-1:0]     rd;
    logic [DW-1:0]     din;
    logic [NR*AW-1:0]  raddr;
    logic              mark_en;
    logic [AW-1:0]     mark_addr;
    logic              clr_req;

    logic [1:0][NR*DW-1:0] rdata_v;
    logic [1:0][NR-1:0]    rpend_v;
    logic [1:0]            busy_v;
    logic [1:0]            done_v;

    int checks;
    int errors;

    regfile_mp #(
        .DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(1'b1), .BYPASS(1'b1)
    ) dut (
        .clk(clk), .rst(rst), .we(we), .rd(rd), .dataIn(din), .raddr(raddr),
        .rdata(rdata_v[0]), .rpend(rpend_v[0]), .mark_en(mark_en), .mark_addr(mark_addr),
        .clr_req(clr_req), .clr_busy(busy_v[0]), .clr_done(done_v[0])
    );

    regfile_mp #(
        .DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(1'b0), .BYPASS(1'b0)
    ) dut_alt (
        .clk(clk), .rst(rst), .we(we), .rd(rd), .dataIn(din), .raddr(raddr),
        .rdata(rdata_v[1]), .rpend(rpend_v[1]), .mark_en(mark_en), .mark_addr(mark_addr),
        .clr_req(clr_req), .clr_busy(busy_v[1]), .clr_done(done_v[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: index 0 = default instance, 1 = alternate instance.
    logic [DW-1:0] m_mem  [2][DEPTH];
    bit            m_pend [2][DEPTH];
    int            sweep_left;

    function automatic bit dropped(int k, int a);
        return (k == 0) && (a == 0);
    endfunction

    function automatic bit byp_hit(int k, int a);
        return (k == 0) && we && (sweep_left == 0) && (int'(rd) == a) && !dropped(k, a);
    endfunction

    function automatic logic [DW-1:0] exp_rd(int k, int a);
        if (dropped(k, a)) return '0;
        if (byp_hit(k, a)) return din;
        return m_mem[k][a];
    endfunction

    function automatic bit exp_pend(int k, int a);
        if (dropped(k, a) || byp_hit(k, a)) return 1'b0;
        return m_pend[k][a];
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++)
            for (int a = 0; a < DEPTH; a++) begin
                m_mem[k][a]  = '0;
                m_pend[k][a] = 1'b0;
            end
        sweep_left = 0;
    endtask

    task automatic model_edge();
        if (sweep_left > 0) begin
            for (int k = 0; k < 2; k++) begin
                m_mem[k][DEPTH - sweep_left]  = '0;
                m_pend[k][DEPTH - sweep_left] = 1'b0;
            end
            sweep_left--;
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (we && !dropped(k, int'(rd))) begin
                    m_mem[k][rd]  = din;
                    m_pend[k][rd] = 1'b0;
                end
                if (mark_en && !dropped(k, int'(mark_addr))) m_pend[k][mark_addr] = 1'b1;
            end
            if (clr_req) sweep_left = DEPTH;
        end
    endtask

    // Advance one clock; inputs stay stable across the edge, next drive is at negedge.
    task automatic tick();
        @(posedge clk);
        if (rst) model_edge();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        we = 1'b0; rd = '0; din = '0; mark_en = 1'b0; mark_addr = '0; clr_req = 1'b0;
    endtask

    task automatic set_ra(int p, int a);
        raddr[p*AW +: AW] = AW'(a);
    endtask

    task automatic test_reset();
        idle_inputs();
        raddr = '0;
        rst = 1'b0;
        model_reset();
        #12;
        @(negedge clk);
        set_ra(0, 0); set_ra(1, 13); set_ra(2, 31);
        #1;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (busy_v[k] !== 1'b0 || done_v[k] !== 1'b0) begin
                errors++;
                $display("FAIL reset_ctrl inst%0d: busy=%b done=%b, expected 0 0", k, busy_v[k], done_v[k]);
            end
            checks++;
            if (rdata_v[k] !== '0 || rpend_v[k] !== '0) begin
                errors++;
                $display("FAIL reset_read inst%0d: rdata=%h rpend=%b, expected 0", k, rdata_v[k], rpend_v[k]);
            end
        end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_write_read();
        logic [DW-1:0] wv [4];
        int            wa [4];
        wa[0] = 1; wa[1] = 2; wa[2] = 6; wa[3] = 8;
        wv[0] = 2001; wv[1] = 4001; wv[2] = 8002; wv[3] = 3002;
        for (int i = 0; i < 4; i++) begin
            we = 1'b1; rd = AW'(wa[i]); din = wv[i];
            tick();
        end
        idle_inputs();
        for (int pair = 0; pair < 2; pair++) begin
            set_ra(0, wa[2*pair]); set_ra(1, wa[2*pair+1]); set_ra(2, 0);
            #1;
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (rdata_v[k][0 +: DW] !== wv[2*pair] || rdata_v[k][DW +: DW] !== wv[2*pair+1]) begin
                    errors++;
                    $display("FAIL write_read inst%0d pair%0d: got %0d %0d, expected %0d %0d", k, pair,
                             rdata_v[k][0 +: DW], rdata_v[k][DW +: DW], wv[2*pair], wv[2*pair+1]);
                end
            end
            tick();
        end
    endtask

    task automatic test_zero_reg();
        we = 1'b1; rd = '0; din = 32'hFFFF; set_ra(0, 0);
        #1;
        checks++;
        if (rdata_v[0][0 +: DW] !== '0 || rpend_v[0][0] !== 1'b0) begin
            errors++;
            $display("FAIL zero_reg_same: rdata=%h rpend=%b, expected 0 0", rdata_v[0][0 +: DW], rpend_v[0][0]);
        end
        tick();
        idle_inputs();
        #1;
        checks++;
        if (rdata_v[0][0 +: DW] !== '0) begin
            errors++;
            $display("FAIL zero_reg_after: rdata=%h, expected 0", rdata_v[0][0 +: DW]);
        end
        checks++;
        if (rdata_v[1][0 +: DW] !== 32'hFFFF) begin
            errors++;
            $display("FAIL r0_writable: rdata=%h, expected 0000ffff", rdata_v[1][0 +: DW]);
        end
        tick();
    endtask

    task automatic test_bypass();
        we = 1'b1; rd = 5'd5; din = 32'hABCD; set_ra(0, 5);
        #1;
        checks++;
        if (rdata_v[0][0 +: DW] !== 32'hABCD) begin
            errors++;
            $display("FAIL bypass_on: rdata=%h, expected 0000abcd", rdata_v[0][0 +: DW]);
        end
        checks++;
        if (rdata_v[1][0 +: DW] !== '0) begin
            errors++;
            $display("FAIL bypass_off: rdata=%h, expected 0", rdata_v[1][0 +: DW]);
        end
        tick();
        idle_inputs();
    endtask

    task automatic test_scoreboard();
        mark_en = 1'b1; mark_addr = 5'd3; set_ra(0, 3);
        #1;
        checks++;
        if (rpend_v[0][0] !== 1'b0) begin
            errors++;
            $display("FAIL mark_latency: rpend=%b, expected 0", rpend_v[0][0]);
        end
        tick();
        idle_inputs();
        #1;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (rpend_v[k][0] !== 1'b1) begin
                errors++;
                $display("FAIL mark_set inst%0d: rpend=%b, expected 1", k, rpend_v[k][0]);
            end
        end
        we = 1'b1; rd = 5'd3; din = 7;
        #1;
        checks++;
        if (rpend_v[0][0] !== 1'b0 || rpend_v[1][0] !== 1'b1) begin
            errors++;
            $display("FAIL write_pend_same: rpend=%b/%b, expected 0/1", rpend_v[0][0], rpend_v[1][0]);
        end
        tick();
        idle_inputs();
        #1;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (rpend_v[k][0] !== 1'b0 || rdata_v[k][0 +: DW] !== 7) begin
                errors++;
                $display("FAIL write_clears inst%0d: rpend=%b rdata=%0d, expected 0 7", k,
                         rpend_v[k][0], rdata_v[k][0 +: DW]);
            end
        end
        we = 1'b1; rd = 5'd4; din = 9; mark_en = 1'b1; mark_addr = 5'd4; set_ra(1, 4);
        tick();
        idle_inputs();
        #1;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (rpend_v[k][1] !== 1'b1 || rdata_v[k][DW +: DW] !== 9) begin
                errors++;
                $display("FAIL mark_wins inst%0d: rpend=%b rdata=%0d, expected 1 9", k,
                         rpend_v[k][1], rdata_v[k][DW +: DW]);
            end
        end
        tick();
    endtask

    task automatic test_sweep();
        int nbusy;
        int done_at;
        for (int a = 0; a < DEPTH; a++) begin
            we = 1'b1; rd = AW'(a); din = $urandom_range(1, 32'h7fff_ffff);
            mark_en = (a % 3 == 0); mark_addr = AW'((a + 9) % DEPTH);
            tick();
        end
        idle_inputs();
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        nbusy = 0;
        done_at = 0;
        for (int n = 0; n < 40; n++) begin
            if (n == 3) begin
                we = 1'b1; rd = 5'd7; din = 55; set_ra(0, 7);
            end else begin
                we = 1'b0; set_ra(0, n % DEPTH);
            end
            #1;
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (busy_v[k] !== (sweep_left > 0) || done_v[k] !== (sweep_left == 1)) begin
                    errors++;
                    $display("FAIL sweep_ctrl inst%0d cyc%0d: busy=%b done=%b, expected %b %b", k, n,
                             busy_v[k], done_v[k], sweep_left > 0, sweep_left == 1);
                end
                checks++;
                if (rdata_v[k][0 +: DW] !== exp_rd(k, n == 3 ? 7 : n % DEPTH)) begin
                    errors++;
                    $display("FAIL sweep_read inst%0d cyc%0d: rdata=%h, expected %h", k, n,
                             rdata_v[k][0 +: DW], exp_rd(k, n == 3 ? 7 : n % DEPTH));
                end
            end
            if (!busy_v[0]) break;
            nbusy++;
            if (done_v[0]) done_at = nbusy;
            tick();
        end
        idle_inputs();
        checks++;
        if (nbusy != DEPTH || done_at != DEPTH) begin
            errors++;
            $display("FAIL sweep_len: busy_cycles=%0d done_at=%0d, expected %0d %0d", nbusy, done_at,
                     DEPTH, DEPTH);
        end
        for (int a = 0; a < DEPTH; a++) begin
            set_ra(0, a);
            #1;
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (rdata_v[k][0 +: DW] !== '0 || rpend_v[k][0] !== 1'b0) begin
                    errors++;
                    $display("FAIL swept inst%0d r%0d: rdata=%h rpend=%b, expected 0 0", k, a,
                             rdata_v[k][0 +: DW], rpend_v[k][0]);
                end
            end
        end
        tick();
    endtask

    task automatic test_reset_mid_sweep();
        for (int a = 1; a < 5; a++) begin
            we = 1'b1; rd = AW'(a); din = $urandom_range(1, 1000);
            tick();
        end
        idle_inputs();
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        for (int n = 0; n < 10; n++) tick();
        set_ra(0, 1); set_ra(1, 2); set_ra(2, 20);
        rst = 1'b0;
        #1;
        model_reset();
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (busy_v[k] !== 1'b0 || done_v[k] !== 1'b0 || rdata_v[k] !== '0 || rpend_v[k] !== '0) begin
                errors++;
                $display("FAIL mid_sweep_reset inst%0d: busy=%b done=%b rdata=%h, expected all 0", k,
                         busy_v[k], done_v[k], rdata_v[k]);
            end
        end
        tick();
        rst = 1'b1;
        tick();
        #1;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (busy_v[k] !== 1'b0) begin
                errors++;
                $display("FAIL idle_after_reset inst%0d: busy=%b, expected 0", k, busy_v[k]);
            end
        end
        tick();
    endtask

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            we        = ($urandom_range(0, 2) != 0);
            rd        = AW'($urandom);
            din       = $urandom;
            mark_en   = ($urandom_range(0, 3) == 0);
            mark_addr = ($urandom_range(0, 2) == 0) ? rd : AW'($urandom);
            clr_req   = ($urandom_range(0, 99) < 2);
            for (int p = 0; p < NR; p++)
                set_ra(p, ($urandom_range(0, 3) == 0) ? int'(rd) : int'($urandom_range(0, DEPTH-1)));
            #1;
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (busy_v[k] !== (sweep_left > 0) || done_v[k] !== (sweep_left == 1)) begin
                    errors++;
                    $display("FAIL rand_ctrl inst%0d cyc%0d: busy=%b done=%b, expected %b %b", k, n,
                             busy_v[k], done_v[k], sweep_left > 0, sweep_left == 1);
                end
                for (int p = 0; p < NR; p++) begin
                    int a;
                    a = int'(raddr[p*AW +: AW]);
                    checks++;
                    if (rdata_v[k][p*DW +: DW] !== exp_rd(k, a) || rpend_v[k][p] !== exp_pend(k, a)) begin
                        errors++;
                        $display("FAIL rand_read inst%0d cyc%0d port%0d r%0d: rdata=%h rpend=%b, expected %h %b",
                                 k, n, p, a, rdata_v[k][p*DW +: DW], rpend_v[k][p], exp_rd(k, a),
                                 exp_pend(k, a));
                    end
                end
            end
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_write_read();
        test_zero_reg();
        test_bypass();
        test_scoreboard();
        test_sweep();
        test_reset_mid_sweep();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
